// File: rtl/i2s_tx_stereo_param.sv
// i2s_tx_stereo_param: parametrised stereo transmitter, Philips I2S or left-justified framing.
// Stereo pairs arrive on a valid/ready stream into a small FIFO; BCLK is clk divided by CLK_DIV.
// Optional build macro: I2S_TX_HOLD_LAST_EN -- on underrun, re-send the previous pair instead of zeros.
module i2s_tx_stereo_param #(
    parameter int unsigned DATA_W     = 24,
    parameter int unsigned SLOT_W     = 32,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [DATA_W-1:0]                    s_left,
    input  logic [DATA_W-1:0]                    s_right,
    input  logic                                 fmt_lj,
    output logic                                 i2s_sck,
    output logic                                 i2s_ws,
    output logic                                 i2s_sd,
    output logic                                 underrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level
);

    localparam int unsigned FRAME_W  = 2 * SLOT_W;
    localparam int unsigned POS_W    = $clog2(FRAME_W);
    localparam int unsigned DIV_W    = $clog2(CLK_DIV);
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned HALF_DIV = CLK_DIV / 2;
    localparam logic [SLOT_W-1:0] MSB_MASK = SLOT_W'(1) << (SLOT_W - 1);

    typedef struct packed {
        logic [DATA_W-1:0] left;
        logic [DATA_W-1:0] right;
    } pair_t;

    // state registers
    logic [DIV_W-1:0] div_q,    div_d;
    logic             sck_q,    sck_d;
    logic [POS_W-1:0] pos_q,    pos_d;
    logic             ws_q,     ws_d;
    logic             sd_q,     sd_d;
    logic             ur_q,     ur_d;
    logic             fmt_q,    fmt_d;
    pair_t            pair_q,   pair_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q,  count_d;
    logic             ready_q,  ready_d;
    pair_t            mem_q [FIFO_DEPTH];

    // combinational helpers
    logic              fe;
    logic              frame_start;
    logic              push;
    logic              pop;
    logic              right_ch;
    logic [POS_W-1:0]  slot_bit;
    logic [POS_W-1:0]  pos_next;
    logic [DATA_W-1:0] sample;
    logic [SLOT_W-1:0] slot_word;
    logic [SLOT_W-1:0] bit_mask;
    logic              sd_bit;
    logic              ws_lj;
    logic              ws_i2s;

    // Next-state: divider, frame position, FIFO bookkeeping and serial outputs
    always_comb begin
        div_d       = div_q;
        sck_d       = sck_q;
        pos_d       = pos_q;
        ws_d        = ws_q;
        sd_d        = sd_q;
        ur_d        = 1'b0;
        fmt_d       = fmt_q;
        pair_d      = pair_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        ready_d     = ready_q;
        right_ch    = 1'b0;
        slot_bit    = '0;
        pos_next    = '0;
        sample      = '0;
        slot_word   = '0;
        bit_mask    = '0;
        sd_bit      = 1'b0;
        ws_lj       = 1'b0;
        ws_i2s      = 1'b0;

        // BCLK divider; FE is the wrap back to zero, which is also the sck fall
        fe    = (div_q == DIV_W'(CLK_DIV - 1));
        div_d = fe ? '0 : div_q + DIV_W'(1);
        sck_d = (div_d >= DIV_W'(HALF_DIV));

        frame_start = fe && (pos_q == POS_W'(FRAME_W - 1));
        if (fe) begin
            pos_d = frame_start ? '0 : pos_q + POS_W'(1);
        end

        // FIFO: push from the stream, pop only at frame start
        push = s_valid && ready_q;
        pop  = frame_start && (count_q != '0);
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d != LVL_W'(FIFO_DEPTH));

        // Frame start: latch format, load the new pair or handle underrun
        if (frame_start) begin
            fmt_d = fmt_lj;
            ur_d  = (count_q == '0);
            if (pop) begin
                pair_d = mem_q[rd_ptr_q];
            end else begin
`ifdef I2S_TX_HOLD_LAST_EN
                pair_d = pair_q;
`else
                pair_d = '0;
`endif
            end
        end

        // Serial bit for the new position: sample left-aligned in its slot, MSB first
        right_ch  = (pos_d >= POS_W'(SLOT_W));
        slot_bit  = right_ch ? pos_d - POS_W'(SLOT_W) : pos_d;
        sample    = right_ch ? pair_d.right : pair_d.left;
        slot_word = SLOT_W'(sample) << (SLOT_W - DATA_W);
        bit_mask  = MSB_MASK >> slot_bit;
        sd_bit    = |(slot_word & bit_mask);

        // WS: LJ follows the slot, I2S leads it by one BCLK
        pos_next = (pos_d == POS_W'(FRAME_W - 1)) ? '0 : pos_d + POS_W'(1);
        ws_lj    = (pos_d >= POS_W'(SLOT_W));
        ws_i2s   = (pos_next >= POS_W'(SLOT_W));

        if (fe) begin
            sd_d = sd_bit;
            ws_d = fmt_d ? ws_lj : ws_i2s;
        end
    end

    // State register with asynchronous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q    <= '0;
            sck_q    <= 1'b0;
            pos_q    <= POS_W'(FRAME_W - 1);
            ws_q     <= 1'b0;
            sd_q     <= 1'b0;
            ur_q     <= 1'b0;
            fmt_q    <= 1'b0;
            pair_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            div_q    <= div_d;
            sck_q    <= sck_d;
            pos_q    <= pos_d;
            ws_q     <= ws_d;
            sd_q     <= sd_d;
            ur_q     <= ur_d;
            fmt_q    <= fmt_d;
            pair_q   <= pair_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    // FIFO storage; emptiness is tracked by the pointers and count only
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {s_left, s_right};
        end
    end

    assign s_ready    = ready_q;
    assign i2s_sck    = sck_q;
    assign i2s_ws     = ws_q;
    assign i2s_sd     = sd_q;
    assign underrun   = ur_q;
    assign fifo_level = count_q;

endmodule

// File: tb/tb_i2s_tx_stereo_param.sv
// tb_i2s_tx_stereo_param: directed, table-driven bench for i2s_tx_stereo_param (24/32/4/4).
// Honours I2S_TX_HOLD_LAST_EN for the expected underrun frame contents.
module tb_i2s_tx_stereo_param;

    localparam logic [63:0] WS_LJ  = 64'h00000000_FFFFFFFF;
    localparam logic [63:0] WS_I2S = 64'h00000001_FFFFFFFE;
`ifdef I2S_TX_HOLD_LAST_EN
    localparam logic [63:0] UR_SD  = 64'hFFFFFF00_00000100;
`else
    localparam logic [63:0] UR_SD  = 64'h0;
`endif

    logic        clk;
    logic        reset_n;
    logic        s_valid;
    logic        s_ready;
    logic [23:0] s_left;
    logic [23:0] s_right;
    logic        fmt_lj;
    logic        i2s_sck;
    logic        i2s_ws;
    logic        i2s_sd;
    logic        underrun;
    logic [2:0]  fifo_level;

    int n_chk  = 0;
    int n_pass = 0;
    int ur_cnt = 0;

    typedef struct {
        logic        push;
        logic        fmt;
        logic [23:0] l;
        logic [23:0] r;
        logic [63:0] sd;
        logic [63:0] ws;
        int          ur;
    } row_t;

    row_t rows [7];

    i2s_tx_stereo_param #(
        .DATA_W(24), .SLOT_W(32), .CLK_DIV(4), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_left(s_left), .s_right(s_right), .fmt_lj(fmt_lj),
        .i2s_sck(i2s_sck), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd),
        .underrun(underrun), .fifo_level(fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (underrun === 1'b1) ur_cnt <= ur_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Runs n_ticks clk cycles from a frame start, capturing sd/ws per BCLK
    task automatic run_frame(input int n_ticks, input int push_t,
                             input logic [23:0] pl, input logic [23:0] pr,
                             input int fmt_t, input logic fmt_v,
                             output logic [63:0] sd_w, output logic [63:0] ws_w,
                             output int sck_err, output int lvl0, output int ur_d);
        int ur0;
        sd_w = '0; ws_w = '0; sck_err = 0; lvl0 = 0; ur0 = ur_cnt;
        for (int t = 0; t < n_ticks; t++) begin
            if (t == push_t) begin
                s_valid = 1'b1; s_left = pl; s_right = pr;
            end else begin
                s_valid = 1'b0;
            end
            if (t == fmt_t) fmt_lj = fmt_v;
            if (t % 4 == 0) begin
                sd_w[63 - t/4] = i2s_sd;
                ws_w[63 - t/4] = i2s_ws;
            end
            if (i2s_sck !== ((t % 4) >= 2)) sck_err++;
            if (t == 0) lvl0 = int'(fifo_level);
            @(negedge clk);
        end
        ur_d = ur_cnt - ur0;
    endtask

    // Release reset, push one pair, check first FE timing, end at first frame's p=0
    task automatic release_prime(input logic [23:0] l, input logic [23:0] r, input logic f, input string tag);
        reset_n = 1'b1;
        s_valid = 1'b1; s_left = l; s_right = r; fmt_lj = f;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk({tag, "_sck_before_fe"}, i2s_sck, 1);
        chk({tag, "_sd_before_fe"}, i2s_sd, 0);
        @(negedge clk);
        chk({tag, "_sck_after_fe"}, i2s_sck, 0);
    endtask

    initial begin
        logic [63:0] sd_w, ws_w;
        int          sck_err, lvl0, ur_d;
        int          np_t, nf_t;
        logic [23:0] nl, nr;
        logic        nf;
        logic [23:0] fl [5];
        logic [23:0] fr [5];

        rows[0] = '{1'b1, 1'b1, 24'hABCDEF, 24'h123456, 64'hABCDEF00_12345600, WS_LJ,  0};
        rows[1] = '{1'b1, 1'b0, 24'hABCDEF, 24'h123456, 64'hABCDEF00_12345600, WS_I2S, 0};
        rows[2] = '{1'b1, 1'b1, 24'h800001, 24'h7FFFFE, 64'h80000100_7FFFFE00, WS_LJ,  0};
        rows[3] = '{1'b1, 1'b0, 24'hFFFFFF, 24'h000001, 64'hFFFFFF00_00000100, WS_I2S, 0};
        rows[4] = '{1'b0, 1'b1, 24'h0,      24'h0,      UR_SD,                 WS_LJ,  1};
        rows[5] = '{1'b0, 1'b0, 24'h0,      24'h0,      UR_SD,                 WS_I2S, 1};
        rows[6] = '{1'b1, 1'b1, 24'h5A5A5A, 24'hA5A5A5, 64'h5A5A5A00_A5A5A500, WS_LJ,  0};

        fl[0] = 24'h111111; fr[0] = 24'h222222;
        fl[1] = 24'h333333; fr[1] = 24'h444444;
        fl[2] = 24'h555555; fr[2] = 24'h666666;
        fl[3] = 24'h777777; fr[3] = 24'h888888;
        fl[4] = 24'h999999; fr[4] = 24'hAAAAAA;

        reset_n = 1'b0; s_valid = 1'b0; s_left = '0; s_right = '0; fmt_lj = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_sck", i2s_sck, 0);
        chk("rst_ws", i2s_ws, 0);
        chk("rst_sd", i2s_sd, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ready", s_ready, 1);

        release_prime(rows[0].l, rows[0].r, rows[0].fmt, "init");

        // Table: one frame per row; next row's pair pushed and format changed mid-frame
        for (int i = 0; i < 7; i++) begin
            np_t = -1; nf_t = -1; nl = '0; nr = '0; nf = 1'b1;
            if (i < 6) begin
                if (rows[i+1].push) begin
                    np_t = 40; nl = rows[i+1].l; nr = rows[i+1].r;
                end
                nf_t = 80; nf = rows[i+1].fmt;
            end
            run_frame(256, np_t, nl, nr, nf_t, nf, sd_w, ws_w, sck_err, lvl0, ur_d);
            chk($sformatf("row%0d_sd", i), sd_w, rows[i].sd);
            chk($sformatf("row%0d_ws", i), ws_w, rows[i].ws);
            chk($sformatf("row%0d_underrun", i), ur_d, rows[i].ur);
            chk($sformatf("row%0d_sck", i), sck_err, 0);
            chk($sformatf("row%0d_level", i), lvl0, 0);
        end

        // Fill: five back-to-back offers, only four accepted
        for (int k = 0; k < 5; k++) begin
            s_valid = 1'b1; s_left = fl[k]; s_right = fr[k];
            @(negedge clk);
        end
        s_valid = 1'b0;
        chk("fill_level", fifo_level, 4);
        chk("fill_ready", s_ready, 0);
        repeat (250) @(negedge clk);
        chk("prepop_level", fifo_level, 4);
        chk("prepop_ready", s_ready, 0);
        @(negedge clk);
        chk("pop_level", fifo_level, 3);
        chk("pop_ready", s_ready, 1);

        // Drain in order; simultaneous push and pop at a frame start with level 2
        run_frame(256, -1, '0, '0, -1, 1'b1, sd_w, ws_w, sck_err, lvl0, ur_d);
        chk("f0_sd", sd_w, 64'h11111100_22222200);
        chk("f0_level", lvl0, 3);
        run_frame(256, 255, 24'h55AA55, 24'hAA55AA, -1, 1'b1, sd_w, ws_w, sck_err, lvl0, ur_d);
        chk("f1_sd", sd_w, 64'h33333300_44444400);
        chk("f1_level", lvl0, 2);
        run_frame(256, -1, '0, '0, -1, 1'b1, sd_w, ws_w, sck_err, lvl0, ur_d);
        chk("f2_sd", sd_w, 64'h55555500_66666600);
        chk("f2_level_pushpop", lvl0, 2);
        run_frame(256, -1, '0, '0, -1, 1'b1, sd_w, ws_w, sck_err, lvl0, ur_d);
        chk("f3_sd", sd_w, 64'h77777700_88888800);
        chk("f3_level", lvl0, 1);
        chk("f3_underrun", ur_d, 0);

        // Reset in the middle of the right slot (p=32, sck high)
        run_frame(130, 40, 24'h123123, 24'h321321, -1, 1'b1, sd_w, ws_w, sck_err, lvl0, ur_d);
        chk("f4_left_sd", sd_w[63:32], 64'h55AA5500);
        chk("f4_level", lvl0, 0);
        chk("mid_sck", i2s_sck, 1);
        chk("mid_ws", i2s_ws, 1);
        chk("mid_sd", i2s_sd, 1);
        chk("mid_level", fifo_level, 1);
        reset_n = 1'b0;
        #1;
        chk("arst_sck", i2s_sck, 0);
        chk("arst_ws", i2s_ws, 0);
        chk("arst_sd", i2s_sd, 0);
        chk("arst_level", fifo_level, 0);
        chk("arst_ready", s_ready, 1);
        repeat (2) @(negedge clk);

        release_prime(24'hC0FFEE, 24'hBEEF01, 1'b0, "rerst");
        run_frame(256, -1, '0, '0, -1, 1'b0, sd_w, ws_w, sck_err, lvl0, ur_d);
        chk("rerst_sd", sd_w, 64'hC0FFEE00_BEEF0100);
        chk("rerst_ws", ws_w, WS_I2S);
        chk("rerst_level", lvl0, 0);
        chk("rerst_underrun", ur_d, 0);
        chk("rerst_sck", sck_err, 0);
        s_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
